// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl: arm/trigger/post-capture sequencer and read-address translation for a circular sample memory
module la_capture_ctrl #(
    parameter int ADDR_W = 8,
    parameter int TRIG_W = 32
) (
    input  logic              clk,
    input  logic              la_rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_en,
    input  logic [TRIG_W-1:0] probe,
    input  logic [TRIG_W-1:0] trig_value,
    input  logic [TRIG_W-1:0] trig_mask,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W-1:0] post_count,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [1:0]        state,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;
    state_t r_state, w_state_nx;
    logic [ADDR_W-1:0] r_waddr, w_waddr_nx, r_fill_cnt, w_fill_cnt_nx, r_post_rem, w_post_rem_nx;
    logic [ADDR_W-1:0] r_trig_addr, w_trig_addr_nx, r_pre_l, w_pre_l_nx, r_post_l, w_post_l_nx;
    logic [ADDR_W-1:0] w_post_max;
    logic r_triggered, w_triggered_nx, r_done, w_done_nx, w_hit;
    assign w_hit      = sample_en && (((probe ^ trig_value) & trig_mask) == '0);
    assign w_post_max = ~pre_count; // DEPTH-1-pre_count keeps pre + trigger + post within the buffer
    assign mem_we     = sample_en && (r_state == ARMED || r_state == POST);
    assign mem_waddr  = r_waddr;
    assign state      = r_state;
    assign triggered  = r_triggered;
    assign done       = r_done;
    assign trig_addr  = r_trig_addr;
    assign start_addr = r_trig_addr - r_pre_l;
    assign mem_raddr  = start_addr + rd_idx;
    always_comb begin
        w_state_nx     = r_state;
        w_waddr_nx     = mem_we ? r_waddr + 1'b1 : r_waddr;
        w_fill_cnt_nx  = r_fill_cnt;
        w_post_rem_nx  = r_post_rem;
        w_trig_addr_nx = r_trig_addr;
        w_pre_l_nx     = r_pre_l;
        w_post_l_nx    = r_post_l;
        w_triggered_nx = r_triggered;
        w_done_nx      = r_done;
        if (abort) begin
            w_state_nx     = IDLE;
            w_done_nx      = 1'b0;
            w_triggered_nx = 1'b0;
            w_waddr_nx     = '0;
        end else begin
            case (r_state)
                IDLE, DONE: if (arm) begin
                    w_state_nx     = ARMED;
                    w_waddr_nx     = '0;
                    w_fill_cnt_nx  = '0;
                    w_triggered_nx = 1'b0;
                    w_done_nx      = 1'b0;
                    w_pre_l_nx     = pre_count;
                    w_post_l_nx    = (post_count < w_post_max) ? post_count : w_post_max;
                end
                ARMED: if (sample_en) begin
                    w_fill_cnt_nx = (r_fill_cnt == r_pre_l) ? r_fill_cnt : r_fill_cnt + 1'b1;
                    if (w_hit && r_fill_cnt == r_pre_l) begin
                        w_trig_addr_nx = r_waddr;
                        w_triggered_nx = 1'b1;
                        w_post_rem_nx  = r_post_l;
                        w_state_nx     = (r_post_l == '0) ? DONE : POST;
                        w_done_nx      = (r_post_l == '0);
                    end
                end
                POST: if (sample_en) begin
                    w_post_rem_nx = r_post_rem - 1'b1;
                    w_state_nx    = (r_post_rem == ADDR_W'(1)) ? DONE : POST;
                    w_done_nx     = (r_post_rem == ADDR_W'(1));
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge la_rst) begin
        if (la_rst) begin
            r_state     <= IDLE;
            r_waddr     <= '0;
            r_fill_cnt  <= '0;
            r_post_rem  <= '0;
            r_trig_addr <= '0;
            r_pre_l     <= '0;
            r_post_l    <= '0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_waddr     <= w_waddr_nx;
            r_fill_cnt  <= w_fill_cnt_nx;
            r_post_rem  <= w_post_rem_nx;
            r_trig_addr <= w_trig_addr_nx;
            r_pre_l     <= w_pre_l_nx;
            r_post_l    <= w_post_l_nx;
            r_triggered <= w_triggered_nx;
            r_done      <= w_done_nx;
        end
    end
endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb_la_capture_ctrl: vector table, directed corner sequences and random stimulus against a sample-count model
module tb_la_capture_ctrl;
    localparam int AW    = 8;
    localparam int TW    = 32;
    localparam int DEPTH = 1 << AW;
    typedef struct {int arm; int abort; int se; int probe; int we; int st; int wa; int tr;} vec_t;
    logic clk = 1'b0;
    logic la_rst, arm, abort, sample_en, mem_we, triggered, done;
    logic [TW-1:0] probe, trig_value, trig_mask;
    logic [AW-1:0] pre_count, post_count, rd_idx, mem_waddr, mem_raddr, trig_addr, start_addr;
    logic [1:0] state;
    int checks = 0, failures = 0;
    // model: capture active, qualified samples since arm, trigger sample index (-1 none)
    int m_cap, m_n, m_t, m_taddr, m_pre, m_post;
    vec_t tbl[11];

    always #5 clk = ~clk;

    la_capture_ctrl #(.ADDR_W(AW), .TRIG_W(TW)) dut (
        .clk(clk), .la_rst(la_rst), .arm(arm), .abort(abort), .sample_en(sample_en),
        .probe(probe), .trig_value(trig_value), .trig_mask(trig_mask),
        .pre_count(pre_count), .post_count(post_count), .rd_idx(rd_idx),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .state(state),
        .triggered(triggered), .done(done), .trig_addr(trig_addr), .start_addr(start_addr)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int m_state();
        if (m_cap == 0) return 0;
        if (m_t < 0) return 1;
        return (m_n <= m_t + m_post) ? 2 : 3;
    endfunction

    task automatic model_reset();
        m_cap = 0; m_n = 0; m_t = -1; m_taddr = 0; m_pre = 0; m_post = 0;
    endtask

    task automatic model_edge();
        int st = m_state();
        if (abort) begin
            m_cap = 0; m_n = 0; m_t = -1;
        end else if (arm && (st == 0 || st == 3)) begin
            m_cap = 1; m_n = 0; m_t = -1;
            m_pre  = int'(pre_count);
            m_post = (int'(post_count) < DEPTH - 1 - m_pre) ? int'(post_count) : DEPTH - 1 - m_pre;
        end else if (sample_en && (st == 1 || st == 2)) begin
            if (m_t < 0 && m_n >= m_pre && ((probe ^ trig_value) & trig_mask) == '0) begin
                m_t = m_n;
                m_taddr = m_n % DEPTH;
            end
            m_n++;
        end
    endtask

    task automatic check_all();
        int st = m_state();
        int sa = (m_taddr - m_pre + DEPTH) % DEPTH;
        check("state", int'(state), st);
        check("waddr", int'(mem_waddr), m_n % DEPTH);
        check("mem_we", int'(mem_we), int'(sample_en && (st == 1 || st == 2)));
        check("triggered", int'(triggered), int'(m_cap != 0 && m_t >= 0));
        check("done", int'(done), int'(st == 3));
        check("trig_addr", int'(trig_addr), m_taddr);
        check("start_addr", int'(start_addr), sa);
        check("mem_raddr", int'(mem_raddr), (sa + int'(rd_idx)) % DEPTH);
    endtask

    task automatic step(input int a, input int ab, input int se, input logic [TW-1:0] p);
        arm = a[0]; abort = ab[0]; sample_en = se[0]; probe = p;
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic start(input int pre, input int post, input logic [TW-1:0] val, input logic [TW-1:0] mask);
        pre_count = AW'(pre); post_count = AW'(post); trig_value = val; trig_mask = mask;
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 'h00, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 1, 'h00, 1, 1, 1, 0};
        tbl[2]  = '{0, 0, 0, 'hF3, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 1, 'h11, 1, 1, 2, 0};
        tbl[4]  = '{0, 0, 0, 'h13, 0, 1, 2, 0};
        tbl[5]  = '{0, 0, 1, 'hF3, 1, 2, 3, 1};
        tbl[6]  = '{0, 0, 0, 'h00, 0, 2, 3, 1};
        tbl[7]  = '{0, 0, 1, 'h00, 1, 2, 4, 1};
        tbl[8]  = '{0, 0, 0, 'h00, 0, 2, 4, 1};
        tbl[9]  = '{0, 0, 1, 'h00, 1, 3, 5, 1};
        tbl[10] = '{0, 0, 1, 'hF3, 0, 3, 5, 1};
        la_rst = 1'b1; arm = 1'b0; abort = 1'b0; sample_en = 1'b0; probe = '0;
        trig_value = '0; trig_mask = '0; pre_count = '0; post_count = '0; rd_idx = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_all();
        la_rst = 1'b0;
        @(negedge clk);

        start(4, 3, 'h0A, 'hFF);
        for (int p = 0; p < 13; p++) step(0, 0, 1, p);
        check("basic_done_early", int'(done), 0);
        step(0, 0, 1, 13);
        check("basic_done", int'(done), 1);
        check("basic_trig_addr", int'(trig_addr), 10);
        check("basic_start", int'(start_addr), 6);
        for (int i = 0; i < 8; i++) begin
            rd_idx = AW'(i);
            #1 check("basic_raddr", int'(mem_raddr), 6 + i);
        end
        @(negedge clk);

        start(8, 2, 'h55, 'hFF);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, (i == 2 || i == 11) ? 32'h55 : 32'h0);
            if (i == 2) check("prefill_ignored", int'(triggered), 0);
        end
        check("prefill_trig", int'(triggered), 1);
        check("prefill_trig_addr", int'(trig_addr), 11);
        repeat (2) step(0, 0, 1, 0);
        check("prefill_done", int'(done), 1);

        start(16, 20, 'hABC, 'hFFF);
        for (int i = 0; i < 300; i++) step(0, 0, 1, i);
        step(0, 0, 1, 'hABC);
        check("wrap_trig_addr", int'(trig_addr), 'h2C);
        repeat (19) step(0, 0, 1, 0);
        check("wrap_done_early", int'(done), 0);
        step(0, 0, 1, 0);
        check("wrap_done", int'(done), 1);
        check("wrap_start", int'(start_addr), 'h1C);
        rd_idx = 8'h24;
        #1 check("wrap_raddr", int'(mem_raddr), 'h40);
        @(negedge clk);

        start(200, 100, 0, 0);
        repeat (200) step(0, 0, 1, 0);
        check("clamp_armed", int'(state), 1);
        step(0, 0, 1, 0);
        check("clamp_trig_addr", int'(trig_addr), 200);
        repeat (54) step(0, 0, 1, 0);
        check("clamp_done_early", int'(done), 0);
        step(0, 0, 1, 0);
        check("clamp_done", int'(done), 1);
        start(5, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0);
        check("zpost_armed", int'(state), 1);
        step(0, 0, 1, 0);
        check("zpost_state", int'(state), 3);
        check("zpost_done", int'(done), 1);

        pre_count = '0; post_count = 8'd2; trig_value = 'h3; trig_mask = 'h0F;
        step(0, 1, 0, 0);
        foreach (tbl[i]) begin
            sample_en = tbl[i].se[0];
            #1 check("tbl_we", int'(mem_we), tbl[i].we);
            step(tbl[i].arm, tbl[i].abort, tbl[i].se, tbl[i].probe);
            check("tbl_state", int'(state), tbl[i].st);
            check("tbl_waddr", int'(mem_waddr), tbl[i].wa);
            check("tbl_trig", int'(triggered), tbl[i].tr);
        end
        check("tbl_trig_addr", int'(trig_addr), 2);

        pre_count = '0; post_count = 8'd10; trig_mask = '0;
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("armabort_state", int'(state), 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        check("abort_in_post", int'(state), 2);
        step(0, 1, 1, 0);
        sample_en = 1'b1;
        #1 check("abort_state", int'(state), 0);
        check("abort_done", int'(done), 0);
        check("abort_we", int'(mem_we), 0);
        @(negedge clk);

        start(50, 5, 0, 0);
        repeat (10) step(0, 0, 1, 0);
        check("prerst_state", int'(state), 1);
        sample_en = 1'b1;
        @(posedge clk);
        #2 la_rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        la_rst = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            pre_count  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 12));
            post_count = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 12));
            trig_value = $urandom;
            trig_mask  = TW'($urandom_range(0, 7));
            rd_idx     = AW'($urandom);
            step(int'($urandom_range(0, 19) == 0), int'($urandom_range(0, 99) == 0),
                 int'($urandom_range(0, 3) != 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
Trigger and capture sequencer for the logic-analyzer sample memory (256-entry circular buffer by default). Once armed, it writes samples continuously. It then waits for a masked pattern match on a probe bus, records a programmable number of post-trigger samples, and freezes the memory. It also translates a software read index (0 = oldest retained sample) into a physical read address for register readout.

Parameters:
ADDR_W, 8, sample-memory address width; DEPTH = 2^ADDR_W
TRIG_W, 32, probe/trigger compare width

Ports:
clk  input  1  system clock, all state on rising edge
la_rst  input  1  asynchronous, active-high reset
arm  input  1  pulse; start a capture (accepted in IDLE or DONE)
abort  input  1  pulse; return to IDLE from any state
sample_en  input  1  qualifier; a sample is taken this cycle when high
probe  input  TRIG_W  signal compared against the trigger pattern
trig_value  input  TRIG_W  pattern value
trig_mask  input  TRIG_W  1 = bit participates in compare
pre_count  input  ADDR_W  samples required before trigger is accepted
post_count  input  ADDR_W  samples stored after trigger sample
rd_idx  input  ADDR_W  logical read index from software
mem_we  output  1  sample-memory write enable
mem_waddr  output  ADDR_W  sample-memory write address
mem_raddr  output  ADDR_W  physical read address = start_addr + rd_idx (mod DEPTH)
state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
triggered  output  1  trigger seen in current capture
done  output  1  capture complete, memory frozen
trig_addr  output  ADDR_W  physical address holding the trigger sample
start_addr  output  ADDR_W  physical address of oldest retained sample

Behaviour:
- Reset values (async, la_rst=1): state=IDLE, waddr=0, fill_cnt=0, post_rem=0, trig_addr=0, pre_l=0, post_l=0, triggered=0, done=0. All registers clear immediately, mid-capture included; mem_we=0 while reset is asserted.
- mem_we = sample_en && (state==ARMED || state==POST). Combinational, zero latency. mem_waddr = waddr register.
- After each cycle with mem_we=1: waddr <= waddr+1, wrapping DEPTH-1 -> 0.
- hit = sample_en && (((probe ^ trig_value) & trig_mask) == 0). An all-zero mask therefore triggers on any qualified sample.
- IDLE/DONE, arm=1 (abort=0):
  - waddr<=0, fill_cnt<=0, triggered<=0, done<=0, state<=ARMED.
  - pre_l<=pre_count.
  - post_l<=min(post_count, DEPTH-1-pre_count). This clamp guarantees pre + trigger + post <= DEPTH.
- ARMED:
  - Each qualified sample: fill_cnt <= fill_cnt+1, saturating at pre_l.
  - Trigger accepted when hit && fill_cnt==pre_l. The sample in that cycle is written and is the trigger sample.
  - On trigger: trig_addr<=waddr, triggered<=1, post_rem<=post_l.
  - If post_l==0, go to DONE (done<=1); else go to POST.
  - A hit with fill_cnt<pre_l is ignored.
- POST:
  - Each qualified sample decrements post_rem.
  - The sample written while post_rem==1 is the last one; state<=DONE and done<=1 at the same edge.
  - probe is not compared in POST.
- DONE: mem_we=0. trig_addr, start_addr, triggered and done hold until the next arm or abort.
- abort=1 in any state: state<=IDLE, done<=0, triggered<=0, waddr<=0. abort beats arm in the same cycle.
- arm while ARMED or POST: ignored.
- start_addr = trig_addr - pre_l (mod DEPTH), combinational from registers. mem_raddr = start_addr + rd_idx (mod DEPTH), combinational.
- Valid logical samples run from rd_idx 0 to pre_l+post_l. Contents at higher indices are undefined.
- fill_cnt is ADDR_W wide, so pre_count=DEPTH-1 requires 255 samples before the trigger and forces post_l=0.
- sample_en=0 cycles do not advance any counter in any state.

Test Plan:
- Basic capture: pre_count=4, post_count=3, trig_mask=FF, trig_value=0x0A; probe counts 0,1,2,... with sample_en=1 and arm at probe=0. -> trigger at probe=0x0A, trig_addr=10; done asserts on the edge after the sample at waddr 13; start_addr=6; rd_idx 0..7 -> mem_raddr 6..13.
- Pre-fill gating: pre_count=8, pattern present at the 3rd and 12th samples. -> the 3rd sample is ignored; the trigger is the 12th sample (trig_addr=11); triggered=1.
- Wrap-around: pre_count=16, post_count=20, trigger after 300 samples at waddr=0x2C (300 mod 256). -> start_addr=0x1C; done after the sample at waddr 0x40; mem_raddr wraps correctly for rd_idx=0x24.
- Clamp and zero post: pre_count=200, post_count=100. -> post_l=55, done exactly 55 samples after trigger. pre_count=5, post_count=0 -> DONE on the trigger edge; state goes 1 to 3, skipping POST.
- Qualifier and masking: sample_en toggling 1,0,1,0; trig_mask=0x0F, value=0x3. -> waddr advances only on qualified cycles; probe=0xF3 triggers; a match with sample_en=0 does not.
- Abort/reset precedence: arm+abort in the same cycle -> stays IDLE. abort in POST -> IDLE, done=0, mem_we=0 next cycle. la_rst asserted mid-ARMED -> outputs clear asynchronously before the next clk edge.
